pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter and drives the next-PC select code (PC_SEL) plus branch/jump targets consumed by the PC input multiplexer.
- Runs the fetch/execute sequence against an instruction memory with a variable-latency ack handshake, evaluates branch conditions and, optionally, sequences interrupt entry and MRET.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 16, fetch watchdog in cycles; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- IMEM_ADDR  out  32  fetch address, always equal to PC.
- IMEM_RD  out  1  fetch request, held until ack.
- IMEM_ACK  in  1  IR valid this cycle.
- IR  in  32  instruction word from memory.
- RS1, RS2  in  32 each  register-file operands for the latched instruction.
- PC  out  32  current PC.
- IR_LATCH  out  32  instruction held for the datapath.
- EXEC_EN  out  1  one-cycle pulse: IR_LATCH is executing.
- PC_SEL  out  3  000 +4, 001 JALR, 010 BRANCH, 011 JAL, 100 MTVEC, 101 MEPC.
- PC_PLUS4, JALR_TGT, BRANCH_TGT, JAL_TGT  out  32 each  targets for the mux.
- FETCH_ERR  out  1  sticky watchdog timeout flag.
- INTR, MTVEC, MEPC (in, 1/32/32); TRAP_TAKEN (out, 1); TRAP_EPC (out, 32): present only with the optional feature.

Behaviour:
- Reset: RST_N low at a rising edge forces state INIT on any cycle, including mid-fetch. Values: PC=RESET_VEC, IR_LATCH=0, IMEM_RD=0, EXEC_EN=0, PC_SEL=000, FETCH_ERR=0, TRAP_TAKEN=0, TRAP_EPC=0, watchdog count=0.
- States: INIT, FETCH, EXEC, TRAP (feature only), HALT.
- INIT: always goes to FETCH on the next cycle.
- FETCH: IMEM_RD=1 and IMEM_ADDR=PC.
  - IMEM_ACK high: latch IR into IR_LATCH and go to EXEC. Zero-wait ack in the first FETCH cycle is legal.
  - IMEM_ACK low: stay in FETCH and increment the watchdog.
  - Watchdog reaching MAX_WAIT (when MAX_WAIT≠0): set FETCH_ERR, go to HALT.
  - Watchdog clears on every entry to FETCH.
- EXEC: lasts exactly one cycle.
  - EXEC_EN=1 and PC_SEL is decoded combinationally from IR_LATCH[6:0].
  - Opcode 1101111 gives 011; 1100111 gives 001.
  - Opcode 1100011 gives 010 if the condition holds, else 000. funct3 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; funct3 010/011 are never taken.
  - All other opcodes give 000.
  - At the edge the next PC is loaded with bits[1:0] forced to 00, then state goes to FETCH.
- Outside EXEC: PC_SEL=000, EXEC_EN=0.
- Targets (combinational, 32-bit wrap-around, no overflow detection):
  - PC_PLUS4 = PC+4; PC 32'hFFFF_FFFC wraps to 0.
  - JAL_TGT = PC + J-imm.
  - BRANCH_TGT = PC + B-imm.
  - JALR_TGT = (RS1 + I-imm) with bit0 cleared.
- HALT: IMEM_RD=0, PC frozen; exited only by reset.
- Latency: with a zero-wait ack, one instruction completes every 2 cycles.

Optional Feature:
- Macro: PC_SEQ_TRAP_EN.
- Enabled behaviour:
  - INTR is sampled in EXEC. If high, the instruction completes normally, then the next state is TRAP instead of FETCH.
  - TRAP lasts one cycle: TRAP_TAKEN=1, TRAP_EPC=the PC just written, PC_SEL=100, PC<=MTVEC with [1:0]=00, then FETCH.
  - IR_LATCH==32'h3020_0073 (MRET) in EXEC gives PC_SEL=101 and PC<=MEPC.
  - MRET together with INTR: the MRET completes, then TRAP with TRAP_EPC=MEPC.
  - INTR outside EXEC is ignored; the source must hold it level.
  - TRAP_EPC holds its value until the next trap.
- Disabled behaviour:
  - INTR, MTVEC, MEPC, TRAP_TAKEN and TRAP_EPC ports and the TRAP state are absent.
  - MRET decodes as PC_SEL=000.

Decomposition:
- Shared package pc_seq_pkg:
  - enum of PC_SEL codes;
  - FSM state enum;
  - opcode constants (JAL, JALR, BRANCH);
  - funct3 branch constants;
  - MRET encoding.
- Sub-module pc_target_gen: purely combinational; immediate extraction, the four targets and the branch-condition compare. The FSM, PC register and watchdog stay in pc_sequencer.

Test Plan:
- Reset then ack every cycle with IR=NOP (32'h0000_0013) → PC 0,4,8; EXEC_EN every 2nd cycle; PC_SEL=000.
- PC=32'h100, IR=BEQ x1,x2,-8 with RS1=RS2=5 → PC_SEL=010, PC=32'hF8. With RS1=5, RS2=6 → PC_SEL=000, PC=32'h104.
- IR=JALR offset 3 with RS1=32'h201 → PC_SEL=001, JALR_TGT=32'h204, PC=32'h204.
- IMEM_ACK held low with MAX_WAIT=16 → FETCH_ERR=1 after 16 cycles, IMEM_RD=0, PC frozen. RST_N low for one edge → PC=RESET_VEC, FETCH_ERR=0.
- PC_SEQ_TRAP_EN, PC=32'h40, NOP in EXEC with INTR=1, MTVEC=32'h800 → next cycle TRAP_TAKEN=1, TRAP_EPC=32'h44, PC=32'h800. Then MRET with MEPC=32'h44 → PC_SEL=101, PC=32'h44.
- RST_N low while in FETCH with the ack pending → IMEM_RD=0 next cycle, PC=RESET_VEC, INIT then FETCH.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: PC_SEL codes, FSM states and decode constants.
// The TRAP state exists only when PC_SEQ_TRAP_EN is defined.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        PCSEL_PLUS4  = 3'b000,
        PCSEL_JALR   = 3'b001,
        PCSEL_BRANCH = 3'b010,
        PCSEL_JAL    = 3'b011,
        PCSEL_MTVEC  = 3'b100,
        PCSEL_MEPC   = 3'b101
    } pc_sel_e;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3
`ifdef PC_SEQ_TRAP_EN
        ,
        ST_TRAP  = 3'd4
`endif
    } state_e;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] MRET_INSN = 32'h3020_0073;

    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational immediate extraction, next-PC target generation and branch-condition evaluation
// for the instruction currently held in the latch.
module pc_target_gen
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] pc_plus4,
    output logic [31:0] jalr_tgt,
    output logic [31:0] branch_tgt,
    output logic [31:0] jal_tgt,
    output logic        branch_taken
);

    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] jalr_sum;
    logic        cond;

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign pc_plus4   = pc + 32'd4;
    assign jal_tgt    = pc + imm_j;
    assign branch_tgt = pc + imm_b;
    assign jalr_sum   = rs1 + imm_i;
    assign jalr_tgt   = {jalr_sum[31:1], 1'b0};

    always_comb begin
        cond = 1'b0;
        case (ir[14:12])
            F3_BEQ:  cond = (rs1 == rs2);
            F3_BNE:  cond = (rs1 != rs2);
            F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cond = (rs1 <  rs2);
            F3_BGEU: cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = (ir[6:0] == OPC_BRANCH) && cond;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetch/execute FSM with ack handshake, fetch watchdog and next-PC select.
// Optional interrupt entry and MRET sequencing are enabled by defining PC_SEQ_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RD,
    input  logic        IMEM_ACK,
    input  logic [31:0] IR,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    output logic [31:0] PC,
    output logic [31:0] IR_LATCH,
    output logic        EXEC_EN,
    output logic [2:0]  PC_SEL,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] JALR_TGT,
    output logic [31:0] BRANCH_TGT,
    output logic [31:0] JAL_TGT,
`ifdef PC_SEQ_TRAP_EN
    input  logic        INTR,
    input  logic [31:0] MTVEC,
    input  logic [31:0] MEPC,
    output logic        TRAP_TAKEN,
    output logic [31:0] TRAP_EPC,
`endif
    output logic        FETCH_ERR
);

    state_e      state, state_nxt;
    pc_sel_e     sel;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] wd_cnt;
    logic        fetch_err_q;
    logic        wd_hit;
    logic        branch_taken;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic [31:0] jalr_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] jal_tgt;
`ifdef PC_SEQ_TRAP_EN
    logic [31:0] trap_epc_q;
`endif

    pc_target_gen u_tgt (
        .pc           (pc_q),
        .ir           (ir_q),
        .rs1          (RS1),
        .rs2          (RS2),
        .pc_plus4     (pc_plus4),
        .jalr_tgt     (jalr_tgt),
        .branch_tgt   (branch_tgt),
        .jal_tgt      (jal_tgt),
        .branch_taken (branch_taken)
    );

    // Counter holds the number of ack-less FETCH cycles already completed.
    assign wd_hit = (MAX_WAIT != 0) && ((wd_cnt + 32'd1) == 32'(MAX_WAIT));

    always_comb begin
        sel = PCSEL_PLUS4;
        if (state == ST_EXEC) begin
            case (ir_q[6:0])
                OPC_JAL:    sel = PCSEL_JAL;
                OPC_JALR:   sel = PCSEL_JALR;
                OPC_BRANCH: sel = branch_taken ? PCSEL_BRANCH : PCSEL_PLUS4;
                default:    sel = PCSEL_PLUS4;
            endcase
`ifdef PC_SEQ_TRAP_EN
            if (ir_q == MRET_INSN)
                sel = PCSEL_MEPC;
`endif
        end
`ifdef PC_SEQ_TRAP_EN
        if (state == ST_TRAP)
            sel = PCSEL_MTVEC;
`endif
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            PCSEL_JALR:   next_pc = jalr_tgt;
            PCSEL_BRANCH: next_pc = branch_tgt;
            PCSEL_JAL:    next_pc = jal_tgt;
`ifdef PC_SEQ_TRAP_EN
            PCSEL_MTVEC:  next_pc = MTVEC;
            PCSEL_MEPC:   next_pc = MEPC;
`endif
            default:      next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (IMEM_ACK)
                    state_nxt = ST_EXEC;
                else if (wd_hit)
                    state_nxt = ST_HALT;
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
`ifdef PC_SEQ_TRAP_EN
                if (INTR)
                    state_nxt = ST_TRAP;
`endif
            end
`ifdef PC_SEQ_TRAP_EN
            ST_TRAP:  state_nxt = ST_FETCH;
`endif
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_INIT;
            pc_q        <= RESET_VEC;
            ir_q        <= '0;
            wd_cnt      <= '0;
            fetch_err_q <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
            trap_epc_q  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_FETCH && state != ST_FETCH)
                wd_cnt <= '0;
            else if (state == ST_FETCH && !IMEM_ACK)
                wd_cnt <= wd_cnt + 32'd1;
            if (state == ST_FETCH && IMEM_ACK)
                ir_q <= IR;
            if (state == ST_FETCH && !IMEM_ACK && wd_hit)
                fetch_err_q <= 1'b1;
            if (state == ST_EXEC)
                pc_q <= align4(next_pc);
`ifdef PC_SEQ_TRAP_EN
            if (state == ST_TRAP)
                pc_q <= align4(next_pc);
            // EPC is captured at the EXEC edge so it is already valid during the TRAP cycle.
            if (state == ST_EXEC && INTR)
                trap_epc_q <= align4(next_pc);
`endif
        end
    end

    assign IMEM_ADDR  = pc_q;
    assign IMEM_RD    = (state == ST_FETCH);
    assign PC         = pc_q;
    assign IR_LATCH   = ir_q;
    assign EXEC_EN    = (state == ST_EXEC);
    assign PC_SEL     = sel;
    assign PC_PLUS4   = pc_plus4;
    assign JALR_TGT   = jalr_tgt;
    assign BRANCH_TGT = branch_tgt;
    assign JAL_TGT    = jal_tgt;
    assign FETCH_ERR  = fetch_err_q;
`ifdef PC_SEQ_TRAP_EN
    assign TRAP_TAKEN = (state == ST_TRAP);
    assign TRAP_EPC   = trap_epc_q;
`endif

endmodule
